ace_snoop_responder: RTL and testbench
======================================

Name: ace_snoop_responder

Overview:
- Cache-side end of the ACE snoop channels: accepts AC snoop requests, looks up the line in the local cache, returns CRRESP and streams CD data when required, then updates line state.
- Sits between the interconnect's AC/CR/CD channels and the cache controller's tag/data/state ports.
- One snoop outstanding at a time.

Parameters:
AddrWidth, 64, AC address width
DataWidth, 64, CD data beat width
LineBytes, 64, cache line size; Beats = LineBytes*8/DataWidth (must be integer ≥1)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
ac_valid_i / ac_ready_o  in/out  1  AC handshake
ac_addr_i  in  AddrWidth  snoop address
ac_snoop_i  in  4  snoop type (acsnoop_t)
ac_prot_i  in  3  protection (acprot_t), forwarded unused
cr_valid_o / cr_ready_i  out/in  1  CR handshake
cr_resp_o  out  5  crresp_t {wasUnique,isShared,passDirty,error,dataTransfer}
cd_valid_o / cd_ready_i  out/in  1  CD handshake
cd_data_o  out  DataWidth  snoop data beat
cd_last_o  out  1  final beat
lkp_req_o / lkp_gnt_i  out/in  1  tag lookup request/grant
lkp_addr_o  out  AddrWidth  line-aligned lookup address
lkp_valid_i  in  1  lookup result valid (≥1 cycle after grant)
lkp_hit_i, lkp_dirty_i, lkp_unique_i  in  1 each  line status
rd_req_o / rd_gnt_i  out/in  1  data-array beat read
rd_beat_o  out  $clog2(Beats) (min 1)  beat index
rd_data_i  in  DataWidth  read data, valid exactly 1 cycle after rd_req_o&&rd_gnt_i
upd_valid_o / upd_ready_i  out/in  1  state update handshake
upd_state_o  out  2  new line_state_e
upd_addr_o  out  AddrWidth  line address

Behaviour:
- Reset (async, any state): FSM→IDLE; all valid/req outputs 0; cr_resp_o, cd_data_o, cd_last_o, upd_state_o 0; beat counters 0; ac_ready_o=1 (IDLE). Mid-operation reset abandons the snoop without completing CR/CD.
- States: IDLE, LOOKUP, WAIT, RESP, DATA, UPDATE.
- IDLE: ac_ready_o=1 only here. On ac_valid_i: latch address (line-aligned, low log2(LineBytes) bits zeroed) and snoop. DVM_COMPLETE/DVM_MESSAGE → RESP with resp=0. Undefined encodings → RESP with error=1, other bits 0. Otherwise → LOOKUP.
- LOOKUP: lkp_req_o=1 until lkp_gnt_i → WAIT. WAIT: on lkp_valid_i, compute resp from decode table and latch it → RESP.
- Decode table, for hit=1 (miss → all 0, no data, no update):
- READ_ONCE: DT=1, IS=1, PD=0, no update.
- READ_SHARED, READ_CLEAN, READ_NOT_SHARED_DIRTY: DT=1, IS=1, PD=dirty, new state SHARED_CLEAN.
- READ_UNIQUE: DT=1, IS=0, PD=dirty, new state INVALID.
- CLEAN_SHARED: DT=dirty, IS=1, PD=dirty, new state SHARED_CLEAN.
- CLEAN_INVALID, CLEAN_UNIQUE: DT=dirty, IS=0, PD=dirty, new state INVALID.
- MAKE_INVALID: DT=0, IS=0, PD=0, new state INVALID.
- All hit cases: WU=unique.
- RESP: cr_valid_o=1, cr_resp_o stable until cr_ready_i. After the handshake: DT=1 → DATA; else update required → UPDATE; else → IDLE.
- DATA: issue rd_req_o for beats 0..Beats-1 in order, one read in flight. A read is issued only when no CD beat is pending or the pending beat is accepted that cycle. Returned data is loaded into the CD register with cd_valid_o=1; cd_last_o=1 on beat Beats-1. Payload is held stable while cd_ready_i=0. After the last beat's handshake → UPDATE if an update is required, else IDLE.
- UPDATE: upd_valid_o=1, upd_addr_o=latched address, upd_state_o per table, until upd_ready_i → IDLE.
- CR always precedes the first CD beat. The state update always follows the last CD beat, so data is read before invalidation.

Decomposition:
- snoop_pkg holds crresp_t, acsnoop_t, acprot_t and the AC encodings. Add line_state_e (INVALID=0, SHARED_CLEAN=1, UNIQUE_CLEAN=2, UNIQUE_DIRTY=3) to snoop_pkg.
- Sub-module snoop_resp_decode: purely combinational; inputs snoop, hit, dirty, unique; outputs crresp_t, upd_needed, upd_state.

Test Plan:
- READ_SHARED at 0x1000_0040, hit, dirty=1, unique=1 → cr_resp=5'b11101; 8 CD beats, last beat has cd_last_o=1; upd_state=SHARED_CLEAN at 0x1000_0040.
- MAKE_INVALID at 0x2000_0000, hit, dirty=1 → cr_resp=5'b10000 (unique=1) or 5'b00000 (unique=0); no rd_req_o; upd_state=INVALID.
- READ_ONCE miss → cr_resp=0; no CD, no update; ac_ready_o back high 1 cycle after CR handshake.
- ac_snoop=4'b0100 (undefined) → no lkp_req_o; cr_resp=5'b00010. DVM_MESSAGE → cr_resp=0, no lookup.
- READ_UNIQUE hit, cd_ready_i toggled 0/1 randomly → beat order 0..7 preserved, data stable while stalled, upd_valid_o only after the last beat is accepted.
- rst_i asserted during DATA beat 3 → all valids 0 immediately; after release ac_ready_o=1; next snoop completes normally.

Source files
------------

// File: rtl/snoop_pkg.sv
// Shared types and AC snoop encodings for the ACE snoop responder.
package snoop_pkg;

    typedef logic [3:0] acsnoop_t;
    typedef logic [2:0] acprot_t;

    typedef struct packed {
        logic was_unique;
        logic is_shared;
        logic pass_dirty;
        logic error;
        logic data_transfer;
    } crresp_t;

    typedef enum logic [1:0] {
        INVALID      = 2'd0,
        SHARED_CLEAN = 2'd1,
        UNIQUE_CLEAN = 2'd2,
        UNIQUE_DIRTY = 2'd3
    } line_state_e;

    localparam acsnoop_t SNP_READ_ONCE             = 4'b0000;
    localparam acsnoop_t SNP_READ_SHARED           = 4'b0001;
    localparam acsnoop_t SNP_READ_CLEAN            = 4'b0010;
    localparam acsnoop_t SNP_READ_NOT_SHARED_DIRTY = 4'b0011;
    localparam acsnoop_t SNP_READ_UNIQUE           = 4'b0111;
    localparam acsnoop_t SNP_CLEAN_SHARED          = 4'b1000;
    localparam acsnoop_t SNP_CLEAN_INVALID         = 4'b1001;
    localparam acsnoop_t SNP_CLEAN_UNIQUE          = 4'b1011;
    localparam acsnoop_t SNP_MAKE_INVALID          = 4'b1101;
    localparam acsnoop_t SNP_DVM_COMPLETE          = 4'b1110;
    localparam acsnoop_t SNP_DVM_MESSAGE           = 4'b1111;

    localparam crresp_t RESP_ERROR = 5'b00010;

    function automatic logic is_dvm(input acsnoop_t s);
        return (s == SNP_DVM_COMPLETE) || (s == SNP_DVM_MESSAGE);
    endfunction

    function automatic logic is_lookup_snoop(input acsnoop_t s);
        case (s)
            SNP_READ_ONCE, SNP_READ_SHARED, SNP_READ_CLEAN, SNP_READ_NOT_SHARED_DIRTY,
            SNP_READ_UNIQUE, SNP_CLEAN_SHARED, SNP_CLEAN_INVALID, SNP_CLEAN_UNIQUE,
            SNP_MAKE_INVALID: return 1'b1;
            default:          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/snoop_resp_decode.sv
// Maps snoop type and looked-up line status to CRRESP and the follow-up line state.
module snoop_resp_decode
    import snoop_pkg::*;
(
    input  logic [3:0]  snoop,
    input  logic        hit,
    input  logic        dirty,
    input  logic        line_unique,
    output crresp_t     resp,
    output logic        upd_needed,
    output line_state_e upd_state
);

    // Response and next-state lookup; a miss leaves everything at zero
    always_comb begin
        resp       = '0;
        upd_needed = 1'b0;
        upd_state  = INVALID;
        if (hit) begin
            resp.was_unique = line_unique;
            case (snoop)
                SNP_READ_ONCE: begin
                    resp.data_transfer = 1'b1;
                    resp.is_shared     = 1'b1;
                end
                SNP_READ_SHARED, SNP_READ_CLEAN, SNP_READ_NOT_SHARED_DIRTY: begin
                    resp.data_transfer = 1'b1;
                    resp.is_shared     = 1'b1;
                    resp.pass_dirty    = dirty;
                    upd_needed         = 1'b1;
                    upd_state          = SHARED_CLEAN;
                end
                SNP_READ_UNIQUE: begin
                    resp.data_transfer = 1'b1;
                    resp.pass_dirty    = dirty;
                    upd_needed         = 1'b1;
                    upd_state          = INVALID;
                end
                SNP_CLEAN_SHARED: begin
                    resp.data_transfer = dirty;
                    resp.is_shared     = 1'b1;
                    resp.pass_dirty    = dirty;
                    upd_needed         = 1'b1;
                    upd_state          = SHARED_CLEAN;
                end
                SNP_CLEAN_INVALID, SNP_CLEAN_UNIQUE: begin
                    resp.data_transfer = dirty;
                    resp.pass_dirty    = dirty;
                    upd_needed         = 1'b1;
                    upd_state          = INVALID;
                end
                SNP_MAKE_INVALID: begin
                    upd_needed = 1'b1;
                    upd_state  = INVALID;
                end
                default: begin
                    resp = '0;
                end
            endcase
        end else begin
            resp = '0;
        end
    end

endmodule

// File: rtl/ace_snoop_responder.sv
// ACE snoop responder: AC request -> tag lookup -> CR response -> CD data -> line state update.
module ace_snoop_responder
    import snoop_pkg::*;
#(
    parameter  int AddrWidth = 64,
    parameter  int DataWidth = 64,
    parameter  int LineBytes = 64,
    localparam int Beats     = LineBytes * 8 / DataWidth,
    localparam int BeatW     = (Beats > 1) ? $clog2(Beats) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 ac_valid_i,
    output logic                 ac_ready_o,
    input  logic [AddrWidth-1:0] ac_addr_i,
    input  logic [3:0]           ac_snoop_i,
    input  logic [2:0]           ac_prot_i,
    output logic                 cr_valid_o,
    input  logic                 cr_ready_i,
    output logic [4:0]           cr_resp_o,
    output logic                 cd_valid_o,
    input  logic                 cd_ready_i,
    output logic [DataWidth-1:0] cd_data_o,
    output logic                 cd_last_o,
    output logic                 lkp_req_o,
    input  logic                 lkp_gnt_i,
    output logic [AddrWidth-1:0] lkp_addr_o,
    input  logic                 lkp_valid_i,
    input  logic                 lkp_hit_i,
    input  logic                 lkp_dirty_i,
    input  logic                 lkp_unique_i,
    output logic                 rd_req_o,
    input  logic                 rd_gnt_i,
    output logic [BeatW-1:0]     rd_beat_o,
    input  logic [DataWidth-1:0] rd_data_i,
    output logic                 upd_valid_o,
    input  logic                 upd_ready_i,
    output logic [1:0]           upd_state_o,
    output logic [AddrWidth-1:0] upd_addr_o
);

    localparam int OffW = $clog2(LineBytes);
    localparam logic [BeatW:0] BEATS_C = (BeatW + 1)'(Beats);
    localparam logic [BeatW:0] CNT_ONE = (BeatW + 1)'(1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOOKUP = 3'd1;
    localparam logic [2:0] ST_WAIT   = 3'd2;
    localparam logic [2:0] ST_RESP   = 3'd3;
    localparam logic [2:0] ST_DATA   = 3'd4;
    localparam logic [2:0] ST_UPDATE = 3'd5;

    logic [2:0]           state_r;
    logic [AddrWidth-1:0] addr_r;
    acsnoop_t             snoop_r;
    crresp_t              resp_r;
    logic                 upd_needed_r;
    line_state_e          upd_state_r;
    logic [BeatW:0]       cnt_r;
    logic                 inflight_r;
    logic                 cd_valid_r;
    logic                 cd_last_r;
    logic [DataWidth-1:0] cd_data_r;

    crresp_t              dec_resp_s;
    logic                 dec_upd_needed_s;
    line_state_e          dec_upd_state_s;
    logic [AddrWidth-1:0] aligned_addr_s;
    logic                 issue_s;
    logic                 rd_fire_s;
    logic                 cd_fire_s;
    logic                 unused_bits;

    snoop_resp_decode u_decode (
        .snoop       (snoop_r),
        .hit         (lkp_hit_i),
        .dirty       (lkp_dirty_i),
        .line_unique (lkp_unique_i),
        .resp        (dec_resp_s),
        .upd_needed  (dec_upd_needed_s),
        .upd_state   (dec_upd_state_s)
    );

    assign aligned_addr_s = {ac_addr_i[AddrWidth-1:OffW], {OffW{1'b0}}};
    assign unused_bits    = ^{ac_prot_i, ac_addr_i[OffW-1:0]};

    // A new beat read may start only once the CD register is free or draining this cycle
    assign issue_s   = (state_r == ST_DATA) && !inflight_r && (cnt_r != BEATS_C)
                       && (!cd_valid_r || cd_ready_i);
    assign rd_fire_s = issue_s && rd_gnt_i;
    assign cd_fire_s = cd_valid_r && cd_ready_i;

    assign ac_ready_o  = (state_r == ST_IDLE);
    assign lkp_req_o   = (state_r == ST_LOOKUP);
    assign lkp_addr_o  = addr_r;
    assign cr_valid_o  = (state_r == ST_RESP);
    assign cr_resp_o   = resp_r;
    assign rd_req_o    = issue_s;
    assign rd_beat_o   = cnt_r[BeatW-1:0];
    assign cd_valid_o  = cd_valid_r;
    assign cd_data_o   = cd_data_r;
    assign cd_last_o   = cd_last_r;
    assign upd_valid_o = (state_r == ST_UPDATE);
    assign upd_state_o = upd_state_r;
    assign upd_addr_o  = addr_r;

    // Snoop sequencing, beat bookkeeping and the CD output register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r      <= ST_IDLE;
            addr_r       <= '0;
            snoop_r      <= 4'b0000;
            resp_r       <= '0;
            upd_needed_r <= 1'b0;
            upd_state_r  <= INVALID;
            cnt_r        <= '0;
            inflight_r   <= 1'b0;
            cd_valid_r   <= 1'b0;
            cd_last_r    <= 1'b0;
            cd_data_r    <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (ac_valid_i) begin
                        addr_r       <= aligned_addr_s;
                        snoop_r      <= ac_snoop_i;
                        upd_needed_r <= 1'b0;
                        if (is_dvm(ac_snoop_i)) begin
                            resp_r  <= '0;
                            state_r <= ST_RESP;
                        end else if (!is_lookup_snoop(ac_snoop_i)) begin
                            resp_r  <= RESP_ERROR;
                            state_r <= ST_RESP;
                        end else begin
                            state_r <= ST_LOOKUP;
                        end
                    end
                end
                ST_LOOKUP: begin
                    if (lkp_gnt_i) state_r <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (lkp_valid_i) begin
                        resp_r       <= dec_resp_s;
                        upd_needed_r <= dec_upd_needed_s;
                        upd_state_r  <= dec_upd_state_s;
                        state_r      <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (cr_ready_i) begin
                        cnt_r      <= '0;
                        inflight_r <= 1'b0;
                        if (resp_r.data_transfer) state_r <= ST_DATA;
                        else if (upd_needed_r)    state_r <= ST_UPDATE;
                        else                      state_r <= ST_IDLE;
                    end
                end
                ST_DATA: begin
                    inflight_r <= rd_fire_s;
                    if (rd_fire_s) cnt_r <= cnt_r + CNT_ONE;
                    // Read data lands exactly one cycle after the granted request
                    if (inflight_r) begin
                        cd_data_r  <= rd_data_i;
                        cd_valid_r <= 1'b1;
                        cd_last_r  <= (cnt_r == BEATS_C);
                    end else if (cd_fire_s) begin
                        cd_valid_r <= 1'b0;
                        cd_last_r  <= 1'b0;
                        if (cd_last_r) state_r <= upd_needed_r ? ST_UPDATE : ST_IDLE;
                    end
                end
                ST_UPDATE: begin
                    if (upd_ready_i) state_r <= ST_IDLE;
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ace_snoop_responder.sv
// Scoreboarded bench for ace_snoop_responder with a randomised cache-side model.
module tb_ace_snoop_responder;

    localparam int BW    = 3;
    localparam int K_CR  = 0;
    localparam int K_CD  = 1;
    localparam int K_UPD = 2;
    localparam int NV    = 14;

    typedef struct {
        int          kind;
        logic [63:0] val;
        logic        last;
        logic [1:0]  st;
        bit          then_idle;
    } sb_t;

    typedef struct {
        logic [3:0]  snoop;
        logic [63:0] addr;
        bit          hit;
        bit          dirty;
        bit          uniq;
        logic [4:0]  resp;
        int          beats;
        bit          upd;
        logic [1:0]  st;
        int          lookup;
    } vec_t;

    logic clk = 1'b0;
    logic rst_i;
    logic ac_valid_i, ac_ready_o;
    logic [63:0] ac_addr_i;
    logic [3:0]  ac_snoop_i;
    logic [2:0]  ac_prot_i;
    logic cr_valid_o, cr_ready_i;
    logic [4:0] cr_resp_o;
    logic cd_valid_o, cd_ready_i, cd_last_o;
    logic [63:0] cd_data_o;
    logic lkp_req_o, lkp_gnt_i, lkp_valid_i, lkp_hit_i, lkp_dirty_i, lkp_unique_i;
    logic [63:0] lkp_addr_o;
    logic rd_req_o, rd_gnt_i;
    logic [BW-1:0] rd_beat_o;
    logic [63:0] rd_data_i;
    logic upd_valid_o, upd_ready_i;
    logic [1:0] upd_state_o;
    logic [63:0] upd_addr_o;

    sb_t  sb[$];
    vec_t vecs[NV];
    int   tests = 0;
    int   fails = 0;
    int   lkp_fires, rd_fires, cd_hs, lkp_cnt;
    bit   lkp_fire_seen, rd_fire_seen, held_valid, idle_chk, cd_stall;
    bit   cur_hit, cur_dirty, cur_uniq;
    logic [BW-1:0] rd_beat_seen;
    logic [63:0]   held_data, exp_line;
    logic          held_last;

    always #5 clk = ~clk;

    ace_snoop_responder dut (
        .clk_i(clk), .rst_i(rst_i),
        .ac_valid_i(ac_valid_i), .ac_ready_o(ac_ready_o), .ac_addr_i(ac_addr_i),
        .ac_snoop_i(ac_snoop_i), .ac_prot_i(ac_prot_i),
        .cr_valid_o(cr_valid_o), .cr_ready_i(cr_ready_i), .cr_resp_o(cr_resp_o),
        .cd_valid_o(cd_valid_o), .cd_ready_i(cd_ready_i), .cd_data_o(cd_data_o),
        .cd_last_o(cd_last_o),
        .lkp_req_o(lkp_req_o), .lkp_gnt_i(lkp_gnt_i), .lkp_addr_o(lkp_addr_o),
        .lkp_valid_i(lkp_valid_i), .lkp_hit_i(lkp_hit_i), .lkp_dirty_i(lkp_dirty_i),
        .lkp_unique_i(lkp_unique_i),
        .rd_req_o(rd_req_o), .rd_gnt_i(rd_gnt_i), .rd_beat_o(rd_beat_o), .rd_data_i(rd_data_i),
        .upd_valid_o(upd_valid_o), .upd_ready_i(upd_ready_i), .upd_state_o(upd_state_o),
        .upd_addr_o(upd_addr_o)
    );

    function automatic logic [63:0] beat_data(input logic [63:0] line, input logic [BW-1:0] b);
        return {line[31:0], 29'h0, b} ^ 64'hA5A5_0F0F_3C3C_0000;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        tests++;
        fails++;
        $display("FAIL %s actual=valid required=not-valid", name);
    endtask

    // Cache-side model: lookup, data array and random back-pressure
    initial begin
        lkp_gnt_i = 1'b0; lkp_valid_i = 1'b0; lkp_hit_i = 1'b0; lkp_dirty_i = 1'b0;
        lkp_unique_i = 1'b0; rd_gnt_i = 1'b0; rd_data_i = '0; cr_ready_i = 1'b0;
        cd_ready_i = 1'b0; upd_ready_i = 1'b0; lkp_cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rst_i) begin
                lkp_cnt = 0; lkp_valid_i = 1'b0; lkp_gnt_i = 1'b0; rd_gnt_i = 1'b0;
            end else begin
                lkp_gnt_i = lkp_req_o && ($urandom_range(0, 3) != 0);
                if (lkp_fire_seen) lkp_cnt = 1 + $urandom_range(0, 2);
                lkp_valid_i = 1'b0;
                if (lkp_cnt > 0) begin
                    lkp_cnt--;
                    if (lkp_cnt == 0) lkp_valid_i = 1'b1;
                end
                lkp_hit_i    = lkp_valid_i ? cur_hit   : 1'($urandom_range(0, 1));
                lkp_dirty_i  = lkp_valid_i ? cur_dirty : 1'($urandom_range(0, 1));
                lkp_unique_i = lkp_valid_i ? cur_uniq  : 1'($urandom_range(0, 1));
                rd_gnt_i     = ($urandom_range(0, 3) != 0);
                rd_data_i    = rd_fire_seen ? beat_data(exp_line, rd_beat_seen) : {$urandom, $urandom};
                cd_ready_i   = cd_stall ? 1'($urandom_range(0, 1)) : 1'b1;
                cr_ready_i   = ($urandom_range(0, 3) != 0);
                upd_ready_i  = ($urandom_range(0, 3) != 0);
            end
        end
    end

    // Monitor: handshakes checked against the scoreboard front at the falling edge
    initial begin
        forever begin
            @(negedge clk);
            if (rst_i) begin
                lkp_fire_seen = 1'b0; rd_fire_seen = 1'b0; held_valid = 1'b0; idle_chk = 1'b0;
            end else begin
                if (idle_chk) begin
                    chk("ac_ready_after_cr", 64'(ac_ready_o), 64'd1);
                    idle_chk = 1'b0;
                end
                if (held_valid) begin
                    chk("cd_stall_valid", 64'(cd_valid_o), 64'd1);
                    chk("cd_stall_data", cd_data_o, held_data);
                    chk("cd_stall_last", 64'(cd_last_o), 64'(held_last));
                end
                held_valid = cd_valid_o && !cd_ready_i;
                held_data  = cd_data_o;
                held_last  = cd_last_o;
                lkp_fire_seen = lkp_req_o && lkp_gnt_i;
                if (lkp_fire_seen) lkp_fires++;
                rd_fire_seen = rd_req_o && rd_gnt_i;
                rd_beat_seen = rd_beat_o;
                if (rd_fire_seen) rd_fires++;
                if (cr_valid_o) begin
                    if (sb.size() == 0 || sb[0].kind != K_CR) unexpected("cr_out_of_order");
                    else if (cr_ready_i) begin
                        chk("cr_resp", 64'(cr_resp_o), sb[0].val);
                        idle_chk = sb[0].then_idle;
                        void'(sb.pop_front());
                    end
                end
                if (cd_valid_o) begin
                    if (sb.size() == 0 || sb[0].kind != K_CD) unexpected("cd_out_of_order");
                    else if (cd_ready_i) begin
                        chk("cd_data", cd_data_o, sb[0].val);
                        chk("cd_last", 64'(cd_last_o), 64'(sb[0].last));
                        cd_hs++;
                        void'(sb.pop_front());
                    end
                end
                if (upd_valid_o) begin
                    if (sb.size() == 0 || sb[0].kind != K_UPD) unexpected("upd_out_of_order");
                    else if (upd_ready_i) begin
                        chk("upd_state", 64'(upd_state_o), 64'(sb[0].st));
                        chk("upd_addr", upd_addr_o, sb[0].val);
                        void'(sb.pop_front());
                    end
                end
            end
        end
    end

    task automatic start_snoop(input vec_t v, input bit stall);
        bit ok;
        cd_stall  = stall;
        cur_hit   = v.hit;
        cur_dirty = v.dirty;
        cur_uniq  = v.uniq;
        exp_line  = v.addr & ~64'h3F;
        lkp_fires = 0;
        rd_fires  = 0;
        cd_hs     = 0;
        sb.push_back('{K_CR, 64'(v.resp), 1'b0, 2'd0, (v.beats == 0) && !v.upd});
        for (int b = 0; b < v.beats; b++)
            sb.push_back('{K_CD, beat_data(exp_line, BW'(b)), (b == v.beats - 1), 2'd0, 1'b0});
        if (v.upd) sb.push_back('{K_UPD, exp_line, 1'b0, v.st, 1'b0});
        ac_valid_i = 1'b1;
        ac_addr_i  = v.addr;
        ac_snoop_i = v.snoop;
        ac_prot_i  = 3'($urandom_range(0, 7));
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (ac_ready_o) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        ac_valid_i = 1'b0;
        ac_addr_i  = {$urandom, $urandom};
        if (!ok) chk("ac_handshake_timeout", 64'd0, 64'd1);
    endtask

    task automatic run_snoop(input vec_t v, input bit stall);
        bit done;
        start_snoop(v, stall);
        done = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && ac_ready_o) begin
                done = 1'b1;
                break;
            end
        end
        chk("snoop_complete", 64'(done), 64'd1);
        chk("lookup_count", 64'(lkp_fires), 64'(v.lookup));
        chk("read_count", 64'(rd_fires), 64'(v.beats));
        sb.delete();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t v;
        bit reached;
        rst_i = 1'b1; ac_valid_i = 1'b0; ac_addr_i = '0; ac_snoop_i = 4'b0000;
        ac_prot_i = 3'b000; cd_stall = 1'b0; exp_line = '0;
        cur_hit = 1'b0; cur_dirty = 1'b0; cur_uniq = 1'b0;
        lkp_fires = 0; rd_fires = 0; cd_hs = 0;
        //          snoop    addr                    hit   dirty uniq  resp       beats upd   st    lkp
        vecs[0]  = '{4'b0001, 64'h0000_0000_1000_0057, 1'b1, 1'b1, 1'b1, 5'b11101, 8, 1'b1, 2'd1, 1};
        vecs[1]  = '{4'b1101, 64'h0000_0000_2000_0000, 1'b1, 1'b1, 1'b1, 5'b10000, 0, 1'b1, 2'd0, 1};
        vecs[2]  = '{4'b1101, 64'h0000_0000_2000_0000, 1'b1, 1'b1, 1'b0, 5'b00000, 0, 1'b1, 2'd0, 1};
        vecs[3]  = '{4'b0000, 64'h0000_0000_3000_0080, 1'b0, 1'b1, 1'b1, 5'b00000, 0, 1'b0, 2'd0, 1};
        vecs[4]  = '{4'b0100, 64'h0000_0000_4000_00C0, 1'b1, 1'b1, 1'b1, 5'b00010, 0, 1'b0, 2'd0, 0};
        vecs[5]  = '{4'b1111, 64'h0000_0000_5000_0000, 1'b1, 1'b1, 1'b1, 5'b00000, 0, 1'b0, 2'd0, 0};
        vecs[6]  = '{4'b0000, 64'hFFFF_0000_6000_013F, 1'b1, 1'b1, 1'b1, 5'b11001, 8, 1'b0, 2'd0, 1};
        vecs[7]  = '{4'b1000, 64'h0000_0000_7000_0040, 1'b1, 1'b0, 1'b0, 5'b01000, 0, 1'b1, 2'd1, 1};
        vecs[8]  = '{4'b1001, 64'h0000_0000_8000_0100, 1'b1, 1'b1, 1'b0, 5'b00101, 8, 1'b1, 2'd0, 1};
        vecs[9]  = '{4'b0010, 64'h0000_0000_9000_0200, 1'b1, 1'b0, 1'b1, 5'b11001, 8, 1'b1, 2'd1, 1};
        vecs[10] = '{4'b1011, 64'h0000_0000_A000_0300, 1'b1, 1'b0, 1'b1, 5'b10000, 0, 1'b1, 2'd0, 1};
        vecs[11] = '{4'b1110, 64'h0000_0000_B000_0000, 1'b0, 1'b0, 1'b0, 5'b00000, 0, 1'b0, 2'd0, 0};
        vecs[12] = '{4'b0011, 64'h0000_0000_C000_0400, 1'b1, 1'b1, 1'b0, 5'b01101, 8, 1'b1, 2'd1, 1};
        vecs[13] = '{4'b0111, 64'h0000_0000_D000_0500, 1'b0, 1'b1, 1'b1, 5'b00000, 0, 1'b0, 2'd0, 1};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ac_ready", 64'(ac_ready_o), 64'd1);
        chk("rst_cr_valid", 64'(cr_valid_o), 64'd0);
        chk("rst_cd_valid", 64'(cd_valid_o), 64'd0);
        chk("rst_upd_valid", 64'(upd_valid_o), 64'd0);
        chk("rst_lkp_req", 64'(lkp_req_o), 64'd0);
        chk("rst_rd_req", 64'(rd_req_o), 64'd0);
        chk("rst_cr_resp", 64'(cr_resp_o), 64'd0);
        chk("rst_cd_data", cd_data_o, 64'd0);
        chk("rst_cd_last", 64'(cd_last_o), 64'd0);
        chk("rst_upd_state", 64'(upd_state_o), 64'd0);
        rst_i = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < NV; i++) run_snoop(vecs[i], 1'b0);

        // READ_UNIQUE hit with random CD back-pressure
        v = '{4'b0111, 64'h0000_0000_E000_0600, 1'b1, 1'b1, 1'b1, 5'b10101, 8, 1'b1, 2'd0, 1};
        run_snoop(v, 1'b1);
        v = '{4'b0001, 64'h0000_0000_E000_0640, 1'b1, 1'b0, 1'b0, 5'b01001, 8, 1'b1, 2'd1, 1};
        run_snoop(v, 1'b1);

        // Reset while beat 3 is on its way out
        v = '{4'b0001, 64'h0000_0000_F000_0700, 1'b1, 1'b1, 1'b1, 5'b11101, 8, 1'b1, 2'd1, 1};
        start_snoop(v, 1'b0);
        reached = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (cd_hs >= 3) begin
                reached = 1'b1;
                break;
            end
        end
        chk("reached_beat3", 64'(reached), 64'd1);
        @(posedge clk);
        #1;
        rst_i = 1'b1;
        #1;
        chk("midrst_cr_valid", 64'(cr_valid_o), 64'd0);
        chk("midrst_cd_valid", 64'(cd_valid_o), 64'd0);
        chk("midrst_upd_valid", 64'(upd_valid_o), 64'd0);
        chk("midrst_rd_req", 64'(rd_req_o), 64'd0);
        chk("midrst_lkp_req", 64'(lkp_req_o), 64'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_i = 1'b0;
        @(negedge clk);
        chk("postrst_ac_ready", 64'(ac_ready_o), 64'd1);
        @(posedge clk);
        #1;
        v = '{4'b0111, 64'h0000_0000_F000_0740, 1'b1, 1'b0, 1'b0, 5'b00001, 8, 1'b1, 2'd0, 1};
        run_snoop(v, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
